// File: rtl/pacman_dir_decoder_pkg.sv
// Shared constants for the pacman direction path: direction codes, PS/2 scan codes
// and the receiver state type. Also imported by control_pacman.
package pacman_dir_decoder_pkg;

    typedef enum logic [2:0] {
        DIR_RIGHT = 3'b000,
        DIR_UP    = 3'b001,
        DIR_LEFT  = 3'b010,
        DIR_DOWN  = 3'b011,
        DIR_WAIT  = 3'b100
    } dir_t;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        logic hit;
        dir_t dir;
    } key_map_t;

    // Arrow keys live in the E0-extended page; this only decodes the code itself.
    function automatic key_map_t map_key(input logic [7:0] code);
        key_map_t m;
        m.hit = 1'b1;
        case (code)
            SC_RIGHT: m.dir = DIR_RIGHT;
            SC_UP:    m.dir = DIR_UP;
            SC_LEFT:  m.dir = DIR_LEFT;
            SC_DOWN:  m.dir = DIR_DOWN;
            default: begin
                m.hit = 1'b0;
                m.dir = DIR_WAIT;
            end
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pacman_dir_decoder_ps2_rx.sv
// PS/2 frame receiver: synchronizes the keyboard lines, deserializes 11-bit frames
// and flags parity, stop-bit and inter-edge timeout errors.
module ps2_rx
    import pacman_dir_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]      clk_sync;
    logic [1:0]      dat_sync;
    logic            clk_prev;
    logic            fall;
    logic            dat_bit;
    rx_state_t       state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            parity_ok;
    logic [WD_W-1:0] watchdog;

    assign fall     = clk_prev & ~clk_sync[1];
    assign dat_bit  = dat_sync[1];
    assign byte_out = shift;

    // NOTE: non-blocking assignments so every flop updates from pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            clk_prev   <= 1'b1;
            state      <= RX_IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 8'h00;
            parity_ok  <= 1'b0;
            watchdog   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            dat_sync   <= {dat_sync[0], ps2_dat};
            clk_prev   <= clk_sync[1];
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (state != RX_IDLE && !fall && watchdog == WD_LIMIT) begin
                state     <= RX_IDLE;
                watchdog  <= '0;
                frame_err <= 1'b1;
            end else if (fall) begin
                watchdog <= '0;
                case (state)
                    RX_IDLE: begin
                        if (!dat_bit) begin
                            state   <= RX_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    RX_DATA: begin
                        shift   <= {dat_bit, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        parity_ok <= ^{shift, dat_bit};
                        state     <= RX_STOP;
                    end
                    RX_STOP: begin
                        if (dat_bit && parity_ok) byte_valid <= 1'b1;
                        else                      frame_err  <= 1'b1;
                        state <= RX_IDLE;
                    end
                    default: state <= RX_IDLE;
                endcase
            end else if (state != RX_IDLE) begin
                watchdog <= watchdog + WD_W'(1);
            end
        end
    end

endmodule

// File: rtl/pacman_dir_decoder.sv
// Turns PS/2 arrow-key make/break codes into a held pacman direction,
// pulsing dir_valid only when the direction actually changes.
module pacman_dir_decoder
    import pacman_dir_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [2:0] dir_out,
    output logic       dir_valid,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;
    logic       ext;
    logic       brk;
    dir_t       dir_q;
    dir_t       next_dir;
    key_map_t   key;

    ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clock      (clock),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .byte_out   (rx_byte),
        .byte_valid (rx_valid),
        .frame_err  (rx_err)
    );

    assign dir_out   = dir_q;
    assign frame_err = rx_err;
    assign key       = map_key(rx_byte);

    // NOTE: next_dir gets a default first so no path through the block infers a latch.
    always_comb begin
        next_dir = dir_q;
        if (rx_valid && ext && key.hit) begin
            if (!brk)                next_dir = key.dir;
            else if (key.dir == dir_q) next_dir = DIR_WAIT;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ext       <= 1'b0;
            brk       <= 1'b0;
            dir_q     <= DIR_WAIT;
            dir_valid <= 1'b0;
        end else begin
            dir_valid <= 1'b0;
            if (next_dir != dir_q) begin
                dir_q     <= next_dir;
                dir_valid <= 1'b1;
            end

            // Prefix flags survive only until the next non-prefix byte or a bad frame.
            if (rx_err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (rx_valid) begin
                if (rx_byte == SC_EXT) begin
                    ext <= 1'b1;
                end else if (rx_byte == SC_BREAK) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pacman_dir_decoder.sv
// Bench for pacman_dir_decoder: directed PS/2 frames plus random traffic checked
// against a key-level model of the ext/brk/direction rules.
module tb_pacman_dir_decoder;
    import pacman_dir_decoder_pkg::*;

    localparam int TIMEOUT = 300;
    localparam int HALF    = 8;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [2:0] dir_out;
    logic       dir_valid;
    logic       frame_err;

    int tests  = 0;
    int failed = 0;
    int dv_cnt = 0;
    int fe_cnt = 0;
    int bv_cnt = 0;

    int m_dir = 4;
    bit m_ext = 1'b0;
    bit m_brk = 1'b0;

    pacman_dir_decoder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .dir_out   (dir_out),
        .dir_valid (dir_valid),
        .frame_err (frame_err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (dir_valid === 1'b1) dv_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
        if (dut.u_rx.byte_valid === 1'b1) bv_cnt++;
    end

    initial begin
        #900_000;
        $display("FAIL global_timeout: observed no finish, required finish before 90000 cycles");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(~bad_stop);
        ps2_dat = 1'b1;
        tick(4);
    endtask

    // Key-level model: prefixes set flags, anything else (or an error) clears them.
    function automatic void model_frame(input logic [7:0] b, input bit err);
        int k;
        if (err) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            case (b)
                8'h74:   k = 0;
                8'h75:   k = 1;
                8'h6B:   k = 2;
                8'h72:   k = 3;
                default: k = -1;
            endcase
            if (m_ext && k >= 0) begin
                if (!m_brk)          m_dir = k;
                else if (m_dir == k) m_dir = 4;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    task automatic frame_and_check(input string tag, input logic [7:0] b,
                                   input logic bad_par, input logic bad_stop);
        int dv0;
        int fe0;
        int prev;
        bit err;
        dv0  = dv_cnt;
        fe0  = fe_cnt;
        prev = m_dir;
        err  = bad_par | bad_stop;
        send_frame(b, bad_par, bad_stop);
        model_frame(b, err);
        check({tag, "_dir"}, 32'(dir_out), 32'(m_dir));
        check({tag, "_pulses"}, 32'(dv_cnt - dv0), 32'(m_dir != prev));
        check({tag, "_err"}, 32'(fe_cnt - fe0), 32'(err));
    endtask

    initial begin
        int fe0;
        int bv0;
        int dv0;
        int waited;
        logic [7:0] rb;
        logic [7:0] t74;

        reset_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        tick(2);
        check("reset_dir", 32'(dir_out), 32'd4);
        check("reset_dir_valid", 32'(dir_valid), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        reset_n = 1'b1;
        tick(2);

        frame_and_check("up_e0", 8'hE0, 1'b0, 1'b0);
        frame_and_check("up_make", 8'h75, 1'b0, 1'b0);
        frame_and_check("up_rep_e0", 8'hE0, 1'b0, 1'b0);
        frame_and_check("up_repeat", 8'h75, 1'b0, 1'b0);

        frame_and_check("left_e0", 8'hE0, 1'b0, 1'b0);
        frame_and_check("left_make", 8'h6B, 1'b0, 1'b0);
        frame_and_check("brk_up_e0", 8'hE0, 1'b0, 1'b0);
        frame_and_check("brk_up_f0", 8'hF0, 1'b0, 1'b0);
        frame_and_check("brk_up_other", 8'h75, 1'b0, 1'b0);
        frame_and_check("brk_left_e0", 8'hE0, 1'b0, 1'b0);
        frame_and_check("brk_left_f0", 8'hF0, 1'b0, 1'b0);
        frame_and_check("brk_left_cur", 8'h6B, 1'b0, 1'b0);

        frame_and_check("noext_up", 8'h75, 1'b0, 1'b0);
        frame_and_check("right_e0", 8'hE0, 1'b0, 1'b0);

        // Hand-clocked 74 frame to pin the stop-edge -> dir_out latency.
        t74 = 8'h74;
        dv0 = dv_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(t74[i]);
        ps2_bit(~^t74);
        ps2_dat = 1'b1;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(3);
        check("lat_byte_valid", 32'(dut.u_rx.byte_valid), 32'd1);
        check("lat_dir_old", 32'(dir_out), 32'd4);
        tick(1);
        check("lat_dir_new", 32'(dir_out), 32'd0);
        check("lat_dir_valid", 32'(dir_valid), 32'd1);
        tick(HALF - 4);
        ps2_clk = 1'b1;
        tick(4);
        model_frame(t74, 1'b0);
        check("lat_one_pulse", 32'(dv_cnt - dv0), 32'd1);

        bv0 = bv_cnt;
        frame_and_check("badpar_e0", 8'hE0, 1'b0, 1'b0);
        frame_and_check("badpar_74", 8'h74, 1'b1, 1'b0);
        check("badpar_no_byte", 32'(bv_cnt - bv0), 32'd1);

        fe0 = fe_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'($urandom_range(0, 1)));
        waited = 0;
        while (frame_err !== 1'b1 && waited < TIMEOUT + 50) begin
            tick(1);
            waited++;
        end
        check("timeout_seen", 32'(frame_err), 32'd1);
        check("timeout_delay_ok",
              32'(waited >= TIMEOUT - HALF && waited <= TIMEOUT - HALF + 4), 32'd1);
        tick(5);
        check("timeout_one_pulse", 32'(fe_cnt - fe0), 32'd1);
        check("timeout_idle", 32'(dut.u_rx.state), 32'(RX_IDLE));
        model_frame(8'h00, 1'b1);
        frame_and_check("down_e0", 8'hE0, 1'b0, 1'b0);
        frame_and_check("down_make", 8'h72, 1'b0, 1'b0);

        fe0 = fe_cnt;
        bv0 = bv_cnt;
        dv0 = dv_cnt;
        frame_and_check("rst_e0", 8'hE0, 1'b0, 1'b0);
        bv0 = bv_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        m_dir = 4;
        m_ext = 1'b0;
        m_brk = 1'b0;
        check("midrst_dir", 32'(dir_out), 32'd4);
        check("midrst_idle", 32'(dut.u_rx.state), 32'(RX_IDLE));
        tick(TIMEOUT + 20);
        check("midrst_no_err", 32'(fe_cnt - fe0), 32'd0);
        check("midrst_no_byte", 32'(bv_cnt - bv0), 32'd0);
        check("midrst_no_pulse", 32'(dv_cnt - dv0), 32'd0);
        frame_and_check("midrst_ext_cleared", 8'h75, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0:       rb = 8'hE0;
                1:       rb = 8'hF0;
                2:       rb = 8'h74;
                3:       rb = 8'h75;
                4:       rb = 8'h6B;
                5:       rb = 8'h72;
                default: rb = 8'($urandom_range(0, 255));
            endcase
            frame_and_check($sformatf("rand%0d", n), rb,
                            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 14) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
